seq_alu_engine: RTL and testbench
=================================

# seq_alu_engine

Parametrised successor to the fixed 64-bit, 4-bit-slice accumulate FSM. It loads two N-bit operands as W-bit slices with valid/ready handshakes, then applies a host-issued sequence of up to MAX_OPS opcodes to an N-bit accumulator. It returns the result as W-bit slices with backpressure and flags malformed op sequences. It sits between the TinyTapeout pin wrapper and the pin-level host protocol.

## Interface
Parameters:
- N, 64, operand/accumulator width; N % W == 0, N/W ≥ 2, N even
- W, 4, slice width carried per beat
- MAX_OPS, 8, maximum opcodes per transaction, ≥ 1

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin transaction; sampled only in IDLE
- abort  in  1  cancel transaction; effective in LOAD/EXEC/UNLOAD
- in_valid  in  1  operand slice present
- in_ready  out  1  1 only in LOAD
- in_a  in  W  slice of operand A, LSB slice first
- in_b  in  W  slice of operand B, LSB slice first
- op_valid  in  1  opcode present
- op_ready  out  1  1 only in EXEC
- op_code  in  3  operation select, 0–7
- op_last  in  1  final opcode of the transaction
- out_valid  out  1  1 only in UNLOAD
- out_ready  in  1  host accepts result slice
- out_data  out  W  current result slice; 0 outside UNLOAD
- out_last  out  1  out_valid and final slice
- busy  out  1  state != IDLE
- err  out  1  MAX_OPS reached without op_last; sticky
- state_res  out  2  IDLE=0, LOAD=1, EXEC=2, UNLOAD=3

## Operation
- SLICES = N/W. Slice counter cnt has width $clog2(SLICES). Op counter ops has width $clog2(MAX_OPS+1).
- IDLE: start=1 sets the next state to LOAD and clears A, B, acc, cnt, ops and err on the same edge.
- LOAD: each beat with in_valid&in_ready writes A[cnt*W +: W]=in_a and B[cnt*W +: W]=in_b, then increments cnt. The beat with cnt==SLICES-1 moves to EXEC and resets cnt to 0. With in_valid=0 the block holds.
- EXEC: each op_valid&op_ready beat writes acc <= f(op_code, A, B, acc) and increments ops.
  - If op_last=1, go to UNLOAD.
  - Else if ops==MAX_OPS-1, set err=1 and go to UNLOAD.
- Opcode functions. Arithmetic is modulo 2^N unless stated.
  - 0: (A&B)|acc
  - 1: (A^B)+acc
  - 2: |A−B| ^ acc
  - 3: {acc[N-1:N/2], min(A,B)[N/2-1:0]}
  - 4: max(A,B)+(acc<<1)
  - 5: sat(A+B) & acc, where sat clamps to all-ones when bit N of the (N+1)-bit sum is set
  - 6: ((A&B)+((A^B)>>1)) | acc
  - 7: {A[N-2:0],A[N-1]} ^ B ^ acc
- UNLOAD: out_data = acc[cnt*W +: W], combinational from registers. Each out_valid&out_ready beat increments cnt. The beat with cnt==SLICES-1 (out_last=1) returns to IDLE. With out_ready=0, out_data and cnt hold.
- abort=1 in LOAD, EXEC or UNLOAD forces IDLE on the next edge. No further beats are accepted in that cycle; no error is flagged. abort takes priority over any handshake in the same cycle.
- err clears only on the next accepted start or on rst. acc persists in IDLE until the next start.

## Timing
- Reset values: state IDLE; A, B, acc, cnt, ops and err all 0. Every output is therefore 0, including in_ready, op_ready, out_valid, busy and state_res.
- in_ready, op_ready, out_valid and busy are decoded from registered state only, with no input-to-ready combinational path.
- Minimum latency from start to the first out_valid is 1 + SLICES + 1 cycles: one for start, SLICES load beats, one op.
- Throughput is one beat per cycle in every phase; there are no bubbles between phases.
- An opcode accepted in cycle t is visible in acc at t+1. The first UNLOAD slice reflects the last op.
- rst asserted in any state returns to the reset values on the next edge, overriding abort and start.

## Structure
- Package seq_alu_pkg holds:
  - state_t enum, IDLE/LOAD/EXEC/UNLOAD, 2 bits
  - op_t enum, OP_MASK, OP_XADD, OP_ABSX, OP_MINC, OP_MAXS, OP_SATA, OP_AVGO, OP_ROTX, 3 bits
- Sub-module seq_alu_ops #(N): purely combinational. Inputs are op_code, a, b and acc; the output is the next acc. It implements all eight functions.
- The top level holds the FSM, counters, operand/accumulator registers and handshake decode.

## Test plan
The bench uses N=16, W=4, MAX_OPS=4.
- A=0x1234, B=0x00FF, op 0 with last → acc=0x0034. Slices out are 4,3,0,0, out_last on the 4th, err=0, then IDLE.
- A=0xF000, B=0xF000, op 0 then op 5 with last → acc=0xF000, the saturated case, with output slices 0,0,0,F.
- A=0x8001, B=0x0000, op 7 with last → 0x0003. Then A=0x0010, B=0x0030, op 2 with last → 0x0020.
- Four op 1 beats with op_last=0 → err=1 and UNLOAD after the 4th beat, with op_ready low. err stays 1 in IDLE and clears on the next start.
- Backpressure: hold out_ready=0 for 3 cycles mid-UNLOAD → out_data and out_valid are stable and no slice is skipped. Stall in_valid for 2 cycles in LOAD → operands are captured correctly.
- Reset and abort:
  - abort in EXEC after 1 op → IDLE next cycle with busy=0 and no out_valid.
  - rst pulse during LOAD → all outputs 0 and state_res=0. A following full transaction is correct.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared types for the sequenced accumulator ALU
// Purpose: FSM state and opcode enumerations used by the engine, its
//          interface and the combinational op unit.
// Ports:   none (package)
package seq_alu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      EXEC   = 2'd2,
      UNLOAD = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_MASK = 3'd0,
      OP_XADD = 3'd1,
      OP_ABSX = 3'd2,
      OP_MINC = 3'd3,
      OP_MAXS = 3'd4,
      OP_SATA = 3'd5,
      OP_AVGO = 3'd6,
      OP_ROTX = 3'd7
   } op_t;

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - host-side handshake bundle of the sequenced accumulator ALU
// Purpose: groups control, operand, opcode and result handshakes.
// Ports:   master = host (drives start/abort/in_*/op_*/out_ready),
//          slave  = engine (drives ready/valid/result/status).
interface seq_alu_if
   import seq_alu_pkg::*;
#(
   parameter int W = 4
);
   logic         start;
   logic         abort;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         op_valid;
   logic         op_ready;
   logic [2:0]   op_code;
   logic         op_last;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;
   logic         err;
   state_t       state_res;

   modport master (
      output start, abort, in_valid, in_a, in_b, op_valid, op_code, op_last, out_ready,
      input  in_ready, op_ready, out_valid, out_data, out_last, busy, err, state_res
   );

   modport slave (
      input  start, abort, in_valid, in_a, in_b, op_valid, op_code, op_last, out_ready,
      output in_ready, op_ready, out_valid, out_data, out_last, busy, err, state_res
   );
endinterface

// File: rtl/seq_alu_ops.sv
// rtl/seq_alu_ops.sv - combinational next-accumulator function unit
// Purpose: computes the next accumulator value for all eight opcodes.
// Ports:   op_code (opcode), a/b (operands), acc (current accumulator),
//          acc_nx (next accumulator).
module seq_alu_ops
   import seq_alu_pkg::*;
#(
   parameter int N = 64
)(
   input  op_t          op_code,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] acc,
   output logic [N-1:0] acc_nx
);
   localparam int H = N / 2;

   logic         a_lt_b;
   logic [H-1:0] min_lo;
   logic [N-1:0] max_ab;
   logic [N-1:0] abs_diff;
   logic [N:0]   sum_wide;
   logic [N-1:0] sum_sat;
   logic [N-1:0] rot_a;

   always_comb begin
      a_lt_b   = (a < b);
      min_lo   = a_lt_b ? a[H-1:0] : b[H-1:0];
      max_ab   = a_lt_b ? b : a;
      abs_diff = a_lt_b ? (b - a) : (a - b);
      // Carry out of the N+1 bit sum selects the all-ones clamp
      sum_wide = {1'b0, a} + {1'b0, b};
      sum_sat  = sum_wide[N] ? {N{1'b1}} : sum_wide[N-1:0];
      rot_a    = {a[N-2:0], a[N-1]};

      acc_nx = acc;
      case (op_code)
         OP_MASK: acc_nx = (a & b) | acc;
         OP_XADD: acc_nx = (a ^ b) + acc;
         OP_ABSX: acc_nx = abs_diff ^ acc;
         OP_MINC: acc_nx = {acc[N-1:H], min_lo};
         OP_MAXS: acc_nx = max_ab + (acc << 1);
         OP_SATA: acc_nx = sum_sat & acc;
         // Overflow-free floor average of a and b
         OP_AVGO: acc_nx = ((a & b) + ((a ^ b) >> 1)) | acc;
         OP_ROTX: acc_nx = rot_a ^ b ^ acc;
         default: acc_nx = acc;
      endcase
   end
endmodule

// File: rtl/seq_alu_engine.sv
// rtl/seq_alu_engine.sv - sliced operand load, opcode sequence, sliced result unload
// Purpose: loads A/B as W-bit slices, applies up to MAX_OPS opcodes to an
//          N-bit accumulator, returns the result as W-bit slices.
// Ports:   clk, rst (sync active-high), bus (seq_alu_if.slave: start/abort,
//          in_* load stream, op_* opcode stream, out_* result stream,
//          busy/err/state_res status).
module seq_alu_engine
   import seq_alu_pkg::*;
#(
   parameter int N       = 64,
   parameter int W       = 4,
   parameter int MAX_OPS = 8
)(
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);
   localparam int SLICES = N / W;
   localparam int CW     = $clog2(SLICES);
   localparam int OW     = $clog2(MAX_OPS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLICES - 1);
   localparam logic [OW-1:0] OPS_LAST = OW'(MAX_OPS - 1);

   state_t        state, state_nx;
   logic [N-1:0]  a_q, b_q, acc_q, acc_nx;
   logic [CW-1:0] cnt;
   logic [OW-1:0] ops;
   logic          err_q;
   logic          cnt_wrap;
   logic          load_fire, op_fire, out_fire;

   assign cnt_wrap = (cnt == CNT_LAST);

   seq_alu_ops #(.N(N)) u_ops (
      .op_code (op_t'(bus.op_code)),
      .a       (a_q),
      .b       (b_q),
      .acc     (acc_q),
      .acc_nx  (acc_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Abort suppresses every beat in its cycle, so fire strobes are gated here
   always_comb begin
      state_nx  = state;
      load_fire = 1'b0;
      op_fire   = 1'b0;
      out_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nx = LOAD;
         end
         LOAD: begin
            if (bus.abort) state_nx = IDLE;
            else if (bus.in_valid) begin
               load_fire = 1'b1;
               if (cnt_wrap) state_nx = EXEC;
            end
         end
         EXEC: begin
            if (bus.abort) state_nx = IDLE;
            else if (bus.op_valid) begin
               op_fire = 1'b1;
               if (bus.op_last || ops == OPS_LAST) state_nx = UNLOAD;
            end
         end
         UNLOAD: begin
            if (bus.abort) state_nx = IDLE;
            else if (bus.out_ready) begin
               out_fire = 1'b1;
               if (cnt_wrap) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt   <= '0;
         ops   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt   <= '0;
            ops   <= '0;
            err_q <= 1'b0;
         end
         if (load_fire) begin
            a_q[cnt*W +: W] <= bus.in_a;
            b_q[cnt*W +: W] <= bus.in_b;
         end
         // The same slice counter walks the load and then the unload
         if (load_fire || out_fire)
            cnt <= cnt_wrap ? '0 : cnt + CW'(1);
         if (op_fire) begin
            acc_q <= acc_nx;
            ops   <= ops + OW'(1);
            if (!bus.op_last && ops == OPS_LAST) err_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = (state == LOAD);
   assign bus.op_ready  = (state == EXEC);
   assign bus.out_valid = (state == UNLOAD);
   assign bus.out_data  = (state == UNLOAD) ? acc_q[cnt*W +: W] : '0;
   assign bus.out_last  = (state == UNLOAD) && cnt_wrap;
   assign bus.busy      = (state != IDLE);
   assign bus.err       = err_q;
   assign bus.state_res = state;
endmodule

// File: tb/tb_seq_alu_engine.sv
// tb/tb_seq_alu_engine.sv - directed self-checking bench for seq_alu_engine
module tb_seq_alu_engine;
   localparam int N       = 16;
   localparam int W       = 4;
   localparam int MAX_OPS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_alu_if #(.W(W)) bus ();

   seq_alu_engine #(.N(N), .W(W), .MAX_OPS(MAX_OPS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, bus.state_res, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
   endtask

   // All tasks start and end on a falling edge
   task automatic start_txn();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_state", bus.state_res, 1);
      check("start_err_clr", bus.err, 0);
   endtask

   task automatic load_operands(input logic [15:0] a, input logic [15:0] b, input bit stall);
      for (int i = 0; i < 4; i++) begin
         if (stall && i == 2) begin
            bus.in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("stall_in_ready", bus.in_ready, 1);
         end
         bus.in_valid = 1'b1;
         bus.in_a     = a[i*4 +: 4];
         bus.in_b     = b[i*4 +: 4];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("exec_state", bus.state_res, 2);
   endtask

   task automatic send_op(input logic [2:0] code, input bit last);
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_last  = last;
      @(negedge clk);
      bus.op_valid = 1'b0;
      bus.op_last  = 1'b0;
   endtask

   task automatic unload(input logic [15:0] exp, input bit stall);
      logic [3:0] sl;
      check("unload_state", bus.state_res, 3);
      for (int i = 0; i < 4; i++) begin
         sl = exp[i*4 +: 4];
         if (stall && i == 2) begin
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_data", bus.out_data, sl);
               check("bp_valid", bus.out_valid, 1);
            end
         end
         check($sformatf("slice%0d", i), bus.out_data, sl);
         check($sformatf("last%0d", i), bus.out_last, (i == 3) ? 1 : 0);
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      check_idle("post_unload");
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
      bus.op_valid = 0; bus.op_code = 0; bus.op_last = 0; bus.out_ready = 0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_in_ready", bus.in_ready, 0);
      check("reset_op_ready", bus.op_ready, 0);
      check("reset_out_data", bus.out_data, 0);
      check("reset_err", bus.err, 0);
      rst = 1'b0;
      @(negedge clk);

      // op 0 with last
      start_txn();
      load_operands(16'h1234, 16'h00FF, 0);
      check("op_ready_exec", bus.op_ready, 1);
      send_op(3'd0, 1);
      unload(16'h0034, 0);
      check("t1_err", bus.err, 0);

      // op 0 then saturated op 5
      start_txn();
      load_operands(16'hF000, 16'hF000, 0);
      send_op(3'd0, 0);
      send_op(3'd5, 1);
      unload(16'hF000, 0);

      // rotate, then abs-diff
      start_txn();
      load_operands(16'h8001, 16'h0000, 0);
      send_op(3'd7, 1);
      unload(16'h0003, 0);
      start_txn();
      load_operands(16'h0010, 16'h0030, 0);
      send_op(3'd2, 1);
      unload(16'h0020, 0);

      // max-shift twice then min-combine
      start_txn();
      load_operands(16'h1234, 16'h00FF, 0);
      send_op(3'd4, 0);
      send_op(3'd4, 0);
      send_op(3'd3, 1);
      unload(16'h36FF, 0);
      check("t5_err", bus.err, 0);

      // Op overflow without op_last: acc 3,6,9,C
      start_txn();
      load_operands(16'h0001, 16'h0002, 0);
      for (int k = 0; k < 3; k++) send_op(3'd1, 0);
      check("ovf_still_exec", bus.state_res, 2);
      check("ovf_err_early", bus.err, 0);
      send_op(3'd1, 0);
      check("ovf_op_ready", bus.op_ready, 0);
      check("ovf_err", bus.err, 1);
      unload(16'h000C, 0);
      check("ovf_err_sticky", bus.err, 1);

      // Backpressure on both streams; start clears err
      start_txn();
      load_operands(16'hABCD, 16'h1357, 1);
      send_op(3'd6, 1);
      unload(16'h5F92, 1);

      // Abort in EXEC after one op, with a competing op beat
      start_txn();
      load_operands(16'h0001, 16'h0002, 0);
      send_op(3'd1, 0);
      bus.abort = 1'b1; bus.op_valid = 1'b1; bus.op_last = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0; bus.op_valid = 1'b0; bus.op_last = 1'b0;
      check_idle("abort");
      check("abort_err", bus.err, 0);
      @(negedge clk);
      check("abort_stays_idle", bus.state_res, 0);

      // Reset pulse mid-LOAD, then a full transaction
      start_txn();
      bus.in_valid = 1'b1; bus.in_a = 4'h5; bus.in_b = 4'h6;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check_idle("rst_load");
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_data", bus.out_data, 0);
      start_txn();
      load_operands(16'h00FF, 16'h0F0F, 0);
      send_op(3'd1, 1);
      unload(16'h0FF0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
